// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the sequential divider (slave).
interface div_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] rs1_data;
   logic [WIDTH-1:0] rs2_data;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] div_out;

   modport master (
      output flush, req_valid, funct3, rs1_data, rs2_data, resp_ready,
      input  req_ready, resp_valid, div_out
   );

   modport slave (
      input  flush, req_valid, funct3, rs1_data, rs2_data, resp_ready,
      output req_ready, resp_valid, div_out
   );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to let divide-by-zero and signed-overflow requests bypass CALC.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | iterating, one quotient bit per cycle
//   DONE  | result held until resp_ready
module divider_seq #(
   parameter int WIDTH = 32
) (
   input logic  clk,
   input logic  rst_n,
   div_if.slave div_s
);
   localparam int               CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       f3_q, f3_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rs1_q, rs1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] div_out_q, div_out_d;
   logic             resp_valid_q, resp_valid_d;

   logic             is_signed;
   logic             req_div0;
   logic             req_ovf;
   logic [WIDTH-1:0] rs1_abs;
   logic [WIDTH-1:0] rs2_abs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] res_quo;
   logic [WIDTH-1:0] res_rem;
   logic [WIDTH-1:0] result;

   // Remainder of a zero divide is the untouched dividend, so rs1 is kept raw alongside |rs1|.
   function automatic logic [WIDTH-1:0] special_res(input logic             is_rem,
                                                    input logic             div0,
                                                    input logic [WIDTH-1:0] dividend);
      if (div0) return is_rem ? dividend : {WIDTH{1'b1}};
      else      return is_rem ? {WIDTH{1'b0}} : MIN_NEG;
   endfunction

   assign is_signed = ~div_s.funct3[0];
   assign req_div0  = (div_s.rs2_data == '0);
   assign req_ovf   = is_signed && (div_s.rs1_data == MIN_NEG) && (div_s.rs2_data == '1);
   assign rs1_abs   = (is_signed && div_s.rs1_data[WIDTH-1]) ? -div_s.rs1_data : div_s.rs1_data;
   assign rs2_abs   = (is_signed && div_s.rs2_data[WIDTH-1]) ? -div_s.rs2_data : div_s.rs2_data;

   // Partial remainder stays below 2*divisor, so bit WIDTH of the trial is its sign.
   assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
   assign trial   = rem_sh - {1'b0, dvs_q};
   assign ge      = ~trial[WIDTH];
   assign rem_nx  = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nx  = {quo_q[WIDTH-2:0], ge};
   assign res_quo = q_neg_q ? -quo_nx : quo_nx;
   assign res_rem = r_neg_q ? -rem_nx : rem_nx;

   always_comb begin
      result = f3_q[1] ? res_rem : res_quo;
      if (div0_q || ovf_q) result = special_res(f3_q[1], div0_q, rs1_q);
   end

   always_comb begin
      state_d      = state_q;
      f3_d         = f3_q;
      quo_d        = quo_q;
      rem_d        = rem_q;
      dvs_d        = dvs_q;
      rs1_d        = rs1_q;
      cnt_d        = cnt_q;
      q_neg_d      = q_neg_q;
      r_neg_d      = r_neg_q;
      div0_d       = div0_q;
      ovf_d        = ovf_q;
      div_out_d    = div_out_q;
      resp_valid_d = resp_valid_q;
      if (div_s.flush) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (div_s.req_valid) begin
                  f3_d    = div_s.funct3[1:0];
                  quo_d   = rs1_abs;
                  rem_d   = '0;
                  dvs_d   = rs2_abs;
                  rs1_d   = div_s.rs1_data;
                  cnt_d   = CNT_MAX;
                  q_neg_d = is_signed & (div_s.rs1_data[WIDTH-1] ^ div_s.rs2_data[WIDTH-1]);
                  r_neg_d = is_signed & div_s.rs1_data[WIDTH-1];
                  div0_d  = req_div0;
                  ovf_d   = req_ovf;
                  state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                  if (req_div0 || req_ovf) begin
                     state_d      = DONE;
                     resp_valid_d = 1'b1;
                     div_out_d    = special_res(div_s.funct3[1], req_div0, div_s.rs1_data);
                  end
`endif
               end
            end
            CALC: begin
               quo_d = quo_nx;
               rem_d = rem_nx;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  div_out_d    = result;
               end
            end
            DONE: begin
               if (div_s.resp_ready) begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b0;
               end
            end
            default: begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         f3_q         <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         dvs_q        <= '0;
         rs1_q        <= '0;
         cnt_q        <= '0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         div0_q       <= 1'b0;
         ovf_q        <= 1'b0;
         div_out_q    <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         f3_q         <= f3_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
         dvs_q        <= dvs_d;
         rs1_q        <= rs1_d;
         cnt_q        <= cnt_d;
         q_neg_q      <= q_neg_d;
         r_neg_q      <= r_neg_d;
         div0_q       <= div0_d;
         ovf_q        <= ovf_d;
         div_out_q    <= div_out_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign div_s.req_ready  = (state_q == IDLE);
   assign div_s.resp_valid = resp_valid_q;
   assign div_s.div_out    = div_out_q;
endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: arithmetic vectors, special cases, back-pressure, flush, reset.
module tb_divider_seq;
   localparam int W = 32;
   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;
   localparam int N_LAT = W + 1;
`ifdef DIV_EARLY_OUT_EN
   localparam int SP_LAT = 1;
`else
   localparam int SP_LAT = W + 1;
`endif

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   div_if #(.WIDTH(W)) dif ();
   divider_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .div_s(dif));

   always #5 clk = ~clk;

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      int g;
      @(negedge clk);
      dif.funct3     = f3;
      dif.rs1_data   = a;
      dif.rs2_data   = b;
      dif.req_valid  = 1'b1;
      dif.resp_ready = 1'b1;
      g = 0;
      while (dif.req_ready !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      lat = 1;
      while (dif.resp_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = dif.div_out;
      @(posedge clk); #1;
   endtask

   task automatic wait_resp(output bit ok);
      int g;
      g = 0;
      while (dif.resp_valid !== 1'b1 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      ok = (dif.resp_valid === 1'b1);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", dif.req_ready);
      else n_pass++;
      n_total++;
      if (dif.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", dif.resp_valid);
      else n_pass++;
      n_total++;
      if (dif.div_out !== 32'h0) $display("FAIL reset_div_out got %h want 0", dif.div_out);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL post_reset_req_ready got %b want 1", dif.req_ready);
      else n_pass++;
   endtask

   task automatic test_arith();
      vec_t        v [16];
      logic [31:0] res;
      int          lat;
      v[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         N_LAT};
      v[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          N_LAT};
      v[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  N_LAT};
      v[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  N_LAT};
      v[4]  = '{F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          N_LAT};
      v[5]  = '{F_DIV,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  N_LAT};
      v[6]  = '{F_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,          N_LAT};
      v[7]  = '{F_DIVU, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  N_LAT};
      v[8]  = '{F_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          N_LAT};
      v[9]  = '{F_DIVU, 32'h8000_0000,  32'd1,          32'h8000_0000,  N_LAT};
      v[10] = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SP_LAT};
      v[11] = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          SP_LAT};
      v[12] = '{F_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  SP_LAT};
      v[13] = '{F_REM,  32'd5,          32'd0,          32'd5,          SP_LAT};
      v[14] = '{F_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  SP_LAT};
      v[15] = '{F_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  SP_LAT};
      for (int i = 0; i < 16; i++) begin
         do_op(v[i].f3, v[i].a, v[i].b, res, lat);
         n_total++;
         if (res !== v[i].exp) $display("FAIL arith[%0d]_result got %h want %h", i, res, v[i].exp);
         else n_pass++;
         n_total++;
         if (lat != v[i].lat) $display("FAIL arith[%0d]_latency got %0d want %0d", i, lat, v[i].lat);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      @(negedge clk);
      dif.funct3     = F_DIVU;
      dif.rs1_data   = 32'd100;
      dif.rs2_data   = 32'd7;
      dif.req_valid  = 1'b1;
      dif.resp_ready = 1'b0;
      @(posedge clk); #1;
      dif.rs1_data = 32'd50;
      dif.rs2_data = 32'd5;
      wait_resp(ok);
      n_total++;
      if (!ok) $display("FAIL bp_resp_timeout got 0 want 1");
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if (dif.resp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, dif.resp_valid);
         else n_pass++;
         n_total++;
         if (dif.div_out !== 32'd14) $display("FAIL bp_hold_data[%0d] got %h want %h", i, dif.div_out, 32'd14);
         else n_pass++;
         n_total++;
         if (dif.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d] got %b want 0", i, dif.req_ready);
         else n_pass++;
      end
      dif.resp_ready = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (dif.resp_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", dif.resp_valid);
      else n_pass++;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL bp_no_bypass got %b want 1", dif.req_ready);
      else n_pass++;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      n_total++;
      if (dif.req_ready !== 1'b0) $display("FAIL bp_next_accept got %b want 0", dif.req_ready);
      else n_pass++;
      wait_resp(ok);
      n_total++;
      if (dif.div_out !== 32'd10) $display("FAIL bp_next_result got %h want %h", dif.div_out, 32'd10);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int          seen;
      bit          ok;
      logic [31:0] res;
      int          lat;
      @(negedge clk);
      dif.funct3     = F_DIVU;
      dif.rs1_data   = 32'd100;
      dif.rs2_data   = 32'd7;
      dif.req_valid  = 1'b1;
      dif.resp_ready = 1'b1;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      dif.flush = 1'b1;
      @(posedge clk); #1;
      dif.flush = 1'b0;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL flush_calc_idle got %b want 1", dif.req_ready);
      else n_pass++;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.resp_valid === 1'b1) seen++;
      end
      n_total++;
      if (seen != 0) $display("FAIL flush_no_resp got %0d want 0", seen);
      else n_pass++;

      @(negedge clk);
      dif.rs1_data  = 32'd9;
      dif.rs2_data  = 32'd2;
      dif.flush     = 1'b1;
      dif.req_valid = 1'b1;
      @(posedge clk); #1;
      dif.flush     = 1'b0;
      dif.req_valid = 1'b0;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL flush_beats_req got %b want 1", dif.req_ready);
      else n_pass++;

      @(negedge clk);
      dif.req_valid  = 1'b1;
      dif.resp_ready = 1'b0;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      wait_resp(ok);
      n_total++;
      if (!ok) $display("FAIL flush_done_timeout got 0 want 1");
      else n_pass++;
      @(negedge clk);
      dif.flush      = 1'b1;
      dif.resp_ready = 1'b1;
      @(posedge clk); #1;
      dif.flush = 1'b0;
      n_total++;
      if (dif.resp_valid !== 1'b0) $display("FAIL flush_done_valid got %b want 0", dif.resp_valid);
      else n_pass++;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL flush_done_idle got %b want 1", dif.req_ready);
      else n_pass++;

      do_op(F_DIVU, 32'd9, 32'd2, res, lat);
      n_total++;
      if (res !== 32'd4) $display("FAIL flush_after_result got %h want %h", res, 32'd4);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat;
      @(negedge clk);
      dif.funct3     = F_DIVU;
      dif.rs1_data   = 32'd100;
      dif.rs2_data   = 32'd7;
      dif.req_valid  = 1'b1;
      dif.resp_ready = 1'b1;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (dif.req_ready !== 1'b1) $display("FAIL rst_mid_req_ready got %b want 1", dif.req_ready);
      else n_pass++;
      n_total++;
      if (dif.resp_valid !== 1'b0) $display("FAIL rst_mid_resp_valid got %b want 0", dif.resp_valid);
      else n_pass++;
      n_total++;
      if (dif.div_out !== 32'h0) $display("FAIL rst_mid_div_out got %h want 0", dif.div_out);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
      n_total++;
      if (res !== 32'hFFFF_FFFD) $display("FAIL rst_mid_next_result got %h want %h", res, 32'hFFFF_FFFD);
      else n_pass++;
      n_total++;
      if (lat != N_LAT) $display("FAIL rst_mid_next_latency got %0d want %0d", lat, N_LAT);
      else n_pass++;
   endtask

   initial begin
      dif.flush      = 1'b0;
      dif.req_valid  = 1'b0;
      dif.funct3     = 3'b000;
      dif.rs1_data   = '0;
      dif.rs2_data   = '0;
      dif.resp_ready = 1'b0;
      test_reset();
      test_arith();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
